// File: rtl/framebuffer_arbiter.sv
// Arbitrates the framebuffer RAM port: buffered UART byte writes vs. prioritised 16-bit display reads.
// Read valid 2 cycles after request; writes back-pressure via wr_ready when full; FB_ARB_STATS_EN adds counters.
module framebuffer_arbiter #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int MAX_WR_STALL    = 8,
  parameter int STALL_W         = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        rd_req,
  input  logic [10:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [11:0] ram_address,
  output logic [7:0]  ram_data_out,
  output logic        ram_write_enable,
  output logic        ram_clk_enable,
  input  logic [15:0] ram_data_in,
  output logic        fifo_empty,
  output logic        fifo_full
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0] stat_wr_drops_blocked,
  output logic [15:0] stat_forced_writes
`endif
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [11:0]        r_mem_addr [DEPTH];
  logic [7:0]         r_mem_data [DEPTH];
  logic [STALL_W-1:0] r_stall;
  logic               r_rd_valid;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_stall_hit;
  logic w_grant_rd;
  logic w_grant_wr;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push      = wr_req & ~w_full;
  assign w_pop       = (r_state == WRITE);
  assign w_stall_hit = (r_stall >= STALL_W'(MAX_WR_STALL));

  assign wr_ready   = ~w_full;
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign rd_valid   = r_rd_valid;
  // The RAM macro registers its output, so the word is on ram_data_in exactly in the rd_valid cycle.
  assign rd_data    = r_rd_valid ? ram_data_in : 16'h0000;

  // READ and WRITE always fall back to IDLE, so nothing is in flight when IDLE arbitrates.
  always_comb begin
    w_state_nxt = IDLE;
    w_grant_rd  = 1'b0;
    w_grant_wr  = 1'b0;
    if (r_state == IDLE) begin
      if (rd_req && !w_stall_hit) begin
        w_grant_rd  = 1'b1;
        w_state_nxt = READ;
      end else if (!w_empty) begin
        w_grant_wr  = 1'b1;
        w_state_nxt = WRITE;
      end
    end
  end

  always_comb begin
    ram_clk_enable   = 1'b0;
    ram_write_enable = 1'b0;
    ram_address      = 12'h000;
    ram_data_out     = 8'h00;
    case (r_state)
      READ: begin
        ram_clk_enable = 1'b1;
        ram_address    = {rd_addr, 1'b0};
      end
      WRITE: begin
        ram_clk_enable   = 1'b1;
        ram_write_enable = 1'b1;
        ram_address      = r_mem_addr[r_rd_ptr[AW-1:0]];
        ram_data_out     = r_mem_data[r_rd_ptr[AW-1:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= (r_state == READ);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr[AW-1:0]] <= wr_addr;
      r_mem_data[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // A read grant is only possible below the limit, so the increment saturates at MAX_WR_STALL.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (w_empty || w_grant_wr) begin
      r_stall <= '0;
    end else if (w_grant_rd) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stat_drops;
  logic [15:0] r_stat_forced;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_stat_drops  <= 16'h0000;
      r_stat_forced <= 16'h0000;
    end else begin
      if (wr_req && w_full && (r_stat_drops != 16'hFFFF))
        r_stat_drops <= r_stat_drops + 16'h0001;
      if (w_grant_wr && rd_req && w_stall_hit && (r_stat_forced != 16'hFFFF))
        r_stat_forced <= r_stat_forced + 16'h0001;
    end
  end

  assign stat_wr_drops_blocked = r_stat_drops;
  assign stat_forced_writes    = r_stat_forced;
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a 1-cycle-latency RAM model.
module tb_framebuffer_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [10:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable;
  logic        ram_clk_enable;
  logic [15:0] ram_data_in = 16'h0000;
  logic        fifo_empty;
  logic        fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  framebuffer_arbiter dut (
    .clk_in(clk_in), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable),
    .ram_data_in(ram_data_in), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] ram_word(input logic [11:0] a);
    return (a == 12'h00A) ? 16'hBEEF : {4'h5, a};
  endfunction

  always @(posedge clk_in)
    if (ram_clk_enable && !ram_write_enable) ram_data_in <= ram_word(ram_address);

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      wr_req  = 1'($urandom);
      wr_addr = 12'($urandom);
      wr_data = 8'($urandom);
      rd_req  = 1'($urandom);
      rd_addr = 11'($urandom);
      #1;
      n_checks++;
      if (wr_ready !== 1'b1 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_fifo got ready=%b empty=%b full=%b exp 1 1 0", wr_ready, fifo_empty, fifo_full);
      end
      n_checks++;
      if (ram_clk_enable !== 1'b0 || ram_write_enable !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl got ce=%b we=%b rv=%b exp 0 0 0", ram_clk_enable, ram_write_enable, rd_valid);
      end
      n_checks++;
      if (ram_address !== 12'h000 || ram_data_out !== 8'h00 || rd_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_data got addr=%h dout=%h rdata=%h exp 0", ram_address, ram_data_out, rd_data);
      end
    end
    @(negedge clk_in);
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_write_only;
    int n = 0;
    logic [11:0] ea;
    logic [7:0]  ed;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (ram_clk_enable) begin
        ea = 12'h010 + 12'(n);
        ed = 8'hA0 + 8'(n);
        n_checks++;
        if (ram_write_enable !== 1'b1 || ram_address !== ea || ram_data_out !== ed) begin
          n_fail++;
          $display("FAIL wr_only_op%0d got we=%b addr=%h data=%h exp 1 %h %h", n, ram_write_enable, ram_address, ram_data_out, ea, ed);
        end
        n++;
      end
      if (i < 4) begin
        wr_req = 1'b1; wr_addr = 12'h010 + 12'(i); wr_data = 8'hA0 + 8'(i);
      end else begin
        wr_req = 1'b0;
      end
    end
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL wr_only_count got %0d exp 4", n); end
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL wr_only_empty got %b exp 1", fifo_empty); end
  endtask

  task automatic test_read_only;
    @(negedge clk_in);
    rd_req = 1'b1; rd_addr = 11'h005;
    @(negedge clk_in);
    n_checks++;
    if (ram_clk_enable !== 1'b1 || ram_write_enable !== 1'b0 || ram_address !== 12'h00A || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_grant got ce=%b we=%b addr=%h rv=%b exp 1 0 00a 0", ram_clk_enable, ram_write_enable, ram_address, rd_valid);
    end
    @(negedge clk_in);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_valid got rv=%b data=%h exp 1 beef", rd_valid, rd_data);
    end
    rd_req = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if (rd_valid !== 1'b0 || ram_clk_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after got rv=%b ce=%b exp 0 0", rd_valid, ram_clk_enable);
    end
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_starvation;
    int reads = 0, writes = 0, write_pos = -1;
    logic last_wr = 1'b0;
    @(negedge clk_in);
    rd_req = 1'b1; rd_addr = 11'h123;
    @(negedge clk_in);
    wr_req = 1'b1; wr_addr = 12'h0AB; wr_data = 8'h5C;
    @(negedge clk_in);
    wr_req = 1'b0;
    n_checks++;
    if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL starve_setup got empty=%b exp 0", fifo_empty); end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_in);
      if (ram_clk_enable) begin
        if (last_wr) begin
          n_checks++;
          if (ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL starve_resume got we=%b exp 0", ram_write_enable); end
        end
        if (ram_write_enable) begin
          n_checks++;
          if (ram_address !== 12'h0AB || ram_data_out !== 8'h5C) begin
            n_fail++;
            $display("FAIL starve_wdata got %h/%h exp 0ab/5c", ram_address, ram_data_out);
          end
          writes++;
          if (write_pos < 0) write_pos = reads;
        end else begin
          reads++;
        end
        last_wr = ram_write_enable;
      end
    end
    n_checks++;
    if (write_pos != 8) begin n_fail++; $display("FAIL starve_reads_before_write got %0d exp 8", write_pos); end
    n_checks++;
    if (writes != 1) begin n_fail++; $display("FAIL starve_writes got %0d exp 1", writes); end
    n_checks++;
    if (reads <= 8) begin n_fail++; $display("FAIL starve_reads_after got total=%0d exp >8", reads); end
    rd_req = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_full;
    int k = 0, writes = 0;
    logic [11:0] ea;
    logic [7:0]  ed;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (i == 0) begin rd_req = 1'b1; rd_addr = 11'h040; end
      if (k == 4 && writes == 0) begin
        n_checks++;
        if (wr_ready !== 1'b0 || fifo_full !== 1'b1) begin
          n_fail++;
          $display("FAIL full_blocked cycle %0d got ready=%b full=%b exp 0 1", i, wr_ready, fifo_full);
        end
      end
      if (ram_clk_enable && ram_write_enable) begin
        ea = 12'h020 + 12'(writes);
        ed = 8'hC0 + 8'(writes);
        n_checks++;
        if (ram_address !== ea || ram_data_out !== ed) begin
          n_fail++;
          $display("FAIL full_order wr%0d got %h/%h exp %h/%h", writes, ram_address, ram_data_out, ea, ed);
        end
        writes++;
      end
      if (k < 5) begin
        wr_req = 1'b1; wr_addr = 12'h020 + 12'(k); wr_data = 8'hC0 + 8'(k);
        if (wr_ready) k++;
      end else begin
        wr_req = 1'b0;
      end
      if (k == 5) rd_req = 1'b0;
    end
    n_checks++;
    if (k != 5 || writes != 5) begin n_fail++; $display("FAIL full_count got pushed=%0d written=%0d exp 5 5", k, writes); end
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL full_drain got empty=%b exp 1", fifo_empty); end
  endtask

  task automatic test_async_reset;
    int bad_rv = 0, bad_op = 0;
    @(negedge clk_in);
    rd_req = 1'b1; rd_addr = 11'h077;
    wr_req = 1'b1; wr_addr = 12'h0EE; wr_data = 8'h11;
    @(negedge clk_in);
    wr_req = 1'b0;
    n_checks++;
    if (ram_clk_enable !== 1'b1 || ram_write_enable !== 1'b0 || fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_setup got ce=%b we=%b empty=%b exp 1 0 0", ram_clk_enable, ram_write_enable, fifo_empty);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (ram_clk_enable !== 1'b0 || ram_address !== 12'h000 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate got ce=%b addr=%h rv=%b exp 0 000 0", ram_clk_enable, ram_address, rd_valid);
    end
    n_checks++;
    if (fifo_empty !== 1'b1 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_fifo got empty=%b ready=%b exp 1 1", fifo_empty, wr_ready);
    end
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (rd_valid !== 1'b0) bad_rv++;
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (rd_valid !== 1'b0) bad_rv++;
      if (ram_clk_enable !== 1'b0) bad_op++;
    end
    n_checks++;
    if (bad_rv != 0) begin n_fail++; $display("FAIL arst_no_rd_valid got %0d pulses exp 0", bad_rv); end
    n_checks++;
    if (bad_op != 0) begin n_fail++; $display("FAIL arst_fifo_lost got %0d ram ops exp 0", bad_op); end
  endtask

  initial begin
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_write_only();
    test_read_only();
    test_starvation();
    test_full();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
